// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if
// Waitrequest-style memory bus bundle shared by the fetch port, the data port
// and the memory port of the arbiter.
//   master modport : drives address/read/write/writedata/byteenable,
//                    receives readdata/waitrequest (the side issuing commands).
//   slave modport  : the reverse (the side servicing commands).
interface mem_bus_arbiter_if;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata;
  logic        waitrequest;

  modport master (
    output address, read, write, writedata, byteenable,
    input  readdata, waitrequest
  );

  modport slave (
    input  address, read, write, writedata, byteenable,
    output readdata, waitrequest
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
// Shares one memory bus between the CPU instruction-fetch port and the data
// load/store port. Addresses are forwarded unchanged.
// Ports:
//   clk    : system clock, all state updates on the rising edge
//   reset  : synchronous, active-low reset
//   i_bus  : fetch port (slave); only read is used, write/writedata/byteenable ignored
//   d_bus  : data port (slave); read or write, write wins if both are set
//   m_bus  : memory port (master); m_* command outputs are registered
// Parameter:
//   FAIR   : 1 = round-robin on contention, 0 = data port always wins
module mem_bus_arbiter #(
  parameter bit FAIR = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  mem_bus_arbiter_if.slave         i_bus,
  mem_bus_arbiter_if.slave         d_bus,
  mem_bus_arbiter_if.master        m_bus
);

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;
  typedef enum logic {OWN_I, OWN_D} owner_t;

  state_t      state_q, state_d;
  owner_t      last_owner_q, last_owner_d;
  logic [31:0] m_address_q, m_address_d;
  logic        m_read_q, m_read_d;
  logic        m_write_q, m_write_d;
  logic [31:0] m_writedata_q, m_writedata_d;
  logic [3:0]  m_byteenable_q, m_byteenable_d;

  logic i_req, d_req, mem_done, pick_i, pick_d;
  logic i_complete, d_complete;

  // The fetch port never writes; these lanes exist only because it shares the bus bundle.
  logic unused_i_bus;
  assign unused_i_bus = ^{i_bus.write, i_bus.writedata, i_bus.byteenable};

  assign i_req    = i_bus.read;
  assign d_req    = d_bus.read | d_bus.write;
  assign mem_done = ~m_bus.waitrequest;

  // Fetch wins contention only in fair mode and only when data owned the bus last.
  assign pick_i = i_req & (~d_req | (FAIR & (last_owner_q == OWN_D)));
  assign pick_d = d_req & ~pick_i;

  // NOTE: every variable gets a default at the top of always_comb so no path
  // leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d        = state_q;
    last_owner_d   = last_owner_q;
    m_address_d    = m_address_q;
    m_read_d       = m_read_q;
    m_write_d      = m_write_q;
    m_writedata_d  = m_writedata_q;
    m_byteenable_d = m_byteenable_q;

    case (state_q)
      IDLE: begin
        if (pick_i) begin
          state_d        = GNT_I;
          m_address_d    = i_bus.address;
          m_read_d       = 1'b1;
          m_write_d      = 1'b0;
          m_byteenable_d = 4'hF;
          m_writedata_d  = 32'h0;
        end else if (pick_d) begin
          state_d        = GNT_D;
          m_address_d    = d_bus.address;
          m_write_d      = d_bus.write;
          m_read_d       = ~d_bus.write;
          m_byteenable_d = d_bus.byteenable;
          m_writedata_d  = d_bus.writedata;
        end
      end
      // The access always runs to completion even if the requester drops its
      // request; the result is then simply not consumed.
      GNT_I: begin
        if (mem_done) begin
          state_d      = IDLE;
          m_read_d     = 1'b0;
          m_write_d    = 1'b0;
          last_owner_d = OWN_I;
        end
      end
      GNT_D: begin
        if (mem_done) begin
          state_d      = IDLE;
          m_read_d     = 1'b0;
          m_write_d    = 1'b0;
          last_owner_d = OWN_D;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= IDLE;
      last_owner_q   <= OWN_D;  // first contention after reset goes to fetch
      m_address_q    <= 32'h0;
      m_read_q       <= 1'b0;
      m_write_q      <= 1'b0;
      m_writedata_q  <= 32'h0;
      m_byteenable_q <= 4'h0;
    end else begin
      state_q        <= state_d;
      last_owner_q   <= last_owner_d;
      m_address_q    <= m_address_d;
      m_read_q       <= m_read_d;
      m_write_q      <= m_write_d;
      m_writedata_q  <= m_writedata_d;
      m_byteenable_q <= m_byteenable_d;
    end
  end

  // Completion is gated by reset so an access abandoned by reset is never
  // reported back to its requester.
  assign i_complete = reset & (state_q == GNT_I) & mem_done;
  assign d_complete = reset & (state_q == GNT_D) & mem_done;

  assign i_bus.waitrequest = ~i_complete;
  assign i_bus.readdata    = i_complete ? m_bus.readdata : 32'h0;
  assign d_bus.waitrequest = ~d_complete;
  assign d_bus.readdata    = d_complete ? m_bus.readdata : 32'h0;

  assign m_bus.address    = m_address_q;
  assign m_bus.read       = m_read_q;
  assign m_bus.write      = m_write_q;
  assign m_bus.writedata  = m_writedata_q;
  assign m_bus.byteenable = m_byteenable_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter
// Directed bench for mem_bus_arbiter. Two instances share the same stimulus:
// dut_f (FAIR=1) is checked in every scenario, dut_u (FAIR=0) in the
// fixed-priority contention scenario. The memory side is modelled by the
// bench variables mem_rdata / mem_wait.
module tb_mem_bus_arbiter;

  logic        clk;
  logic        reset;
  logic        i_read;
  logic [31:0] i_address;
  logic        d_read, d_write;
  logic [31:0] d_address, d_writedata;
  logic [3:0]  d_byteenable;
  logic [31:0] mem_rdata;
  logic        mem_wait;

  int checks   = 0;
  int failures = 0;

  mem_bus_arbiter_if ib_f ();
  mem_bus_arbiter_if db_f ();
  mem_bus_arbiter_if mb_f ();
  mem_bus_arbiter_if ib_u ();
  mem_bus_arbiter_if db_u ();
  mem_bus_arbiter_if mb_u ();

  assign ib_f.read = i_read;  assign ib_f.address = i_address;
  assign ib_f.write = 1'b0;   assign ib_f.writedata = 32'h0;  assign ib_f.byteenable = 4'h0;
  assign db_f.read = d_read;  assign db_f.write = d_write;    assign db_f.address = d_address;
  assign db_f.writedata = d_writedata;  assign db_f.byteenable = d_byteenable;
  assign mb_f.readdata = mem_rdata;     assign mb_f.waitrequest = mem_wait;

  assign ib_u.read = i_read;  assign ib_u.address = i_address;
  assign ib_u.write = 1'b0;   assign ib_u.writedata = 32'h0;  assign ib_u.byteenable = 4'h0;
  assign db_u.read = d_read;  assign db_u.write = d_write;    assign db_u.address = d_address;
  assign db_u.writedata = d_writedata;  assign db_u.byteenable = d_byteenable;
  assign mb_u.readdata = mem_rdata;     assign mb_u.waitrequest = mem_wait;

  mem_bus_arbiter #(.FAIR(1'b1)) dut_f (.clk(clk), .reset(reset), .i_bus(ib_f), .d_bus(db_f), .m_bus(mb_f));
  mem_bus_arbiter #(.FAIR(1'b0)) dut_u (.clk(clk), .reset(reset), .i_bus(ib_u), .d_bus(db_u), .m_bus(mb_u));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_read = 1'b0; i_address = 32'h0;
    d_read = 1'b0; d_write = 1'b0; d_address = 32'h0;
    d_writedata = 32'h0; d_byteenable = 4'h0;
  endtask

  task automatic test_reset();
    idle_inputs();
    mem_rdata = 32'hA5A5_A5A5; mem_wait = 1'b0;
    reset = 1'b0;
    step(); step();
    checks++;
    if ({mb_f.read, mb_f.write, mb_f.byteenable, mb_f.address, mb_f.writedata} !== {2'b00, 4'h0, 32'h0, 32'h0}) begin
      failures++;
      $display("FAIL reset_m_outputs got rd=%b wr=%b be=%h a=%h wd=%h want all zero",
               mb_f.read, mb_f.write, mb_f.byteenable, mb_f.address, mb_f.writedata);
    end
    checks++;
    if ({ib_f.waitrequest, db_f.waitrequest, ib_f.readdata, db_f.readdata} !== {2'b11, 64'h0}) begin
      failures++;
      $display("FAIL reset_port_outputs got iw=%b dw=%b ird=%h drd=%h want iw=1 dw=1 rd=0",
               ib_f.waitrequest, db_f.waitrequest, ib_f.readdata, db_f.readdata);
    end
  endtask

  task automatic test_fetch();
    reset = 1'b1;
    i_read = 1'b1; i_address = 32'hBFC0_0000;
    mem_rdata = 32'h2402_0005; mem_wait = 1'b0;
    step();  // cycle 1
    checks++;
    if ({mb_f.read, mb_f.write, mb_f.byteenable, mb_f.address, mb_f.writedata} !== {2'b10, 4'hF, 32'hBFC0_0000, 32'h0}) begin
      failures++;
      $display("FAIL fetch_m_cmd got rd=%b wr=%b be=%h a=%h wd=%h want rd=1 wr=0 be=f a=bfc00000 wd=0",
               mb_f.read, mb_f.write, mb_f.byteenable, mb_f.address, mb_f.writedata);
    end
    checks++;
    if ({ib_f.waitrequest, ib_f.readdata, db_f.waitrequest} !== {1'b0, 32'h2402_0005, 1'b1}) begin
      failures++;
      $display("FAIL fetch_complete got iw=%b ird=%h dw=%b want iw=0 ird=24020005 dw=1",
               ib_f.waitrequest, ib_f.readdata, db_f.waitrequest);
    end
    i_read = 1'b0;
    step();  // cycle 2, back in IDLE
    checks++;
    if ({mb_f.read, mb_f.write, ib_f.waitrequest, ib_f.readdata} !== {2'b00, 1'b1, 32'h0}) begin
      failures++;
      $display("FAIL fetch_idle got rd=%b wr=%b iw=%b ird=%h want rd=0 wr=0 iw=1 ird=0",
               mb_f.read, mb_f.write, ib_f.waitrequest, ib_f.readdata);
    end
  endtask

  task automatic test_wait_states();
    d_write = 1'b1; d_address = 32'h0000_1004;
    d_writedata = 32'hDEAD_BEEF; d_byteenable = 4'b0011;
    mem_rdata = 32'h1234_5678; mem_wait = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      step();
      checks++;
      if ({mb_f.read, mb_f.write, mb_f.byteenable, mb_f.address, mb_f.writedata, db_f.waitrequest}
          !== {2'b01, 4'b0011, 32'h0000_1004, 32'hDEAD_BEEF, 1'b1}) begin
        failures++;
        $display("FAIL wait_hold_c%0d got rd=%b wr=%b be=%h a=%h wd=%h dw=%b want rd=0 wr=1 be=3 a=00001004 wd=deadbeef dw=1",
                 k, mb_f.read, mb_f.write, mb_f.byteenable, mb_f.address, mb_f.writedata, db_f.waitrequest);
      end
    end
    step();  // 4th grant cycle: memory releases
    mem_wait = 1'b0;
    #1;
    checks++;
    if ({mb_f.write, db_f.waitrequest, db_f.readdata, ib_f.waitrequest} !== {1'b1, 1'b0, 32'h1234_5678, 1'b1}) begin
      failures++;
      $display("FAIL wait_complete got wr=%b dw=%b drd=%h iw=%b want wr=1 dw=0 drd=12345678 iw=1",
               mb_f.write, db_f.waitrequest, db_f.readdata, ib_f.waitrequest);
    end
    idle_inputs();
    step();
    checks++;
    if ({mb_f.read, mb_f.write, db_f.waitrequest, db_f.readdata} !== {2'b00, 1'b1, 32'h0}) begin
      failures++;
      $display("FAIL wait_idle got rd=%b wr=%b dw=%b drd=%h want rd=0 wr=0 dw=1 drd=0",
               mb_f.read, mb_f.write, db_f.waitrequest, db_f.readdata);
    end
  endtask

  task automatic test_rw_conflict();
    d_read = 1'b1; d_write = 1'b1; d_address = 32'h0000_2000;
    d_writedata = 32'h0BAD_F00D; d_byteenable = 4'hC; mem_wait = 1'b0;
    step();
    checks++;
    if ({mb_f.read, mb_f.write, mb_f.byteenable, mb_f.writedata, db_f.waitrequest} !== {2'b01, 4'hC, 32'h0BAD_F00D, 1'b0}) begin
      failures++;
      $display("FAIL rw_conflict got rd=%b wr=%b be=%h wd=%h dw=%b want rd=0 wr=1 be=c wd=0badf00d dw=0",
               mb_f.read, mb_f.write, mb_f.byteenable, mb_f.writedata, db_f.waitrequest);
    end
    idle_inputs();
    step();
  endtask

  // Grant pattern as {i_waitrequest, d_waitrequest}: 01 = fetch done, 10 = data done, 11 = none.
  task automatic test_fair();
    logic [1:0]  exp_wait [8] = '{2'b01, 2'b11, 2'b10, 2'b11, 2'b01, 2'b11, 2'b10, 2'b11};
    logic [31:0] exp_addr;
    // Leave fetch as last owner so a missing last_owner reset would show.
    i_read = 1'b1; i_address = 32'h0000_0100; mem_wait = 1'b0;
    step();
    i_read = 1'b0;
    reset = 1'b0;
    step();
    i_read = 1'b1; d_read = 1'b1; d_address = 32'h0000_0200;
    reset = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      exp_addr = (exp_wait[k] == 2'b01) ? 32'h0000_0100 : 32'h0000_0200;
      checks++;
      if ({ib_f.waitrequest, db_f.waitrequest} !== exp_wait[k] ||
          (exp_wait[k] != 2'b11 && mb_f.address !== exp_addr)) begin
        failures++;
        $display("FAIL fair_c%0d got iw_dw=%b a=%h want iw_dw=%b a=%h",
                 k + 1, {ib_f.waitrequest, db_f.waitrequest}, mb_f.address, exp_wait[k], exp_addr);
      end
    end
    idle_inputs();
    step();
  endtask

  task automatic test_unfair();
    reset = 1'b0;
    step();
    i_read = 1'b1; i_address = 32'h0000_0100; d_read = 1'b1; d_address = 32'h0000_0200;
    mem_wait = 1'b0;
    reset = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      checks++;
      if ({ib_u.waitrequest, db_u.waitrequest} !== ((k % 2 == 0) ? 2'b10 : 2'b11)) begin
        failures++;
        $display("FAIL unfair_c%0d got iw_dw=%b want iw_dw=%b",
                 k + 1, {ib_u.waitrequest, db_u.waitrequest}, (k % 2 == 0) ? 2'b10 : 2'b11);
      end
    end
    idle_inputs();
    step();
  endtask

  task automatic test_reset_mid_grant();
    d_read = 1'b1; d_address = 32'h0000_3000; d_byteenable = 4'hF; mem_wait = 1'b1;
    step();  // GNT_D, stalled
    checks++;
    if ({mb_f.read, mb_f.address} !== {1'b1, 32'h0000_3000}) begin
      failures++;
      $display("FAIL midrst_grant got rd=%b a=%h want rd=1 a=00003000", mb_f.read, mb_f.address);
    end
    // Memory releases in the same cycle reset drops: must not complete to the port.
    reset = 1'b0; mem_wait = 1'b0;
    #1;
    checks++;
    if ({db_f.waitrequest, db_f.readdata} !== {1'b1, 32'h0}) begin
      failures++;
      $display("FAIL midrst_gated got dw=%b drd=%h want dw=1 drd=0", db_f.waitrequest, db_f.readdata);
    end
    step();
    checks++;
    if ({mb_f.read, mb_f.write, mb_f.address, mb_f.byteenable, db_f.waitrequest} !== {2'b00, 32'h0, 4'h0, 1'b1}) begin
      failures++;
      $display("FAIL midrst_after got rd=%b wr=%b a=%h be=%h dw=%b want rd=0 wr=0 a=0 be=0 dw=1",
               mb_f.read, mb_f.write, mb_f.address, mb_f.byteenable, db_f.waitrequest);
    end
    d_read = 1'b0; reset = 1'b1;
    step();
    checks++;
    if ({mb_f.read, db_f.waitrequest} !== {1'b0, 1'b1}) begin
      failures++;
      $display("FAIL midrst_idle got rd=%b dw=%b want rd=0 dw=1", mb_f.read, db_f.waitrequest);
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_wait_states();
    test_rw_conflict();
    test_fair();
    test_unfair();
    test_reset_mid_grant();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
